// File: rtl/key_ram_if.sv
// key_ram_if: write/clear/read bus of the multi-context round-key store.
// Carries perr/par_flip_i only when KEY_RAM_PARITY_EN is defined.
interface key_ram_if #(
  parameter int UNROLL = 1,
  parameter int NKEYS  = 10,
  parameter int NCTX   = 2,
  parameter int DW     = 128
);
  localparam int IW = $clog2(NKEYS);
  localparam int CW = NCTX > 1 ? $clog2(NCTX) : 1;
  logic                 wr_en;
  logic [CW-1:0]        wr_ctx;
  logic [IW-1:0]        wr_idx;
  logic [DW-1:0]        wr_data;
  logic                 clr_en;
  logic [CW-1:0]        clr_ctx;
  logic                 rd_en;
  logic [CW-1:0]        rd_ctx;
  logic [IW-1:0]        rd_idx;
  logic                 rd_valid;
  logic                 rd_err;
  logic [DW*UNROLL-1:0] rd_data;
  logic [NCTX-1:0]      ctx_ready;
`ifdef KEY_RAM_PARITY_EN
  logic                 perr;
  logic                 par_flip_i;
`endif
  modport master (
`ifdef KEY_RAM_PARITY_EN
    input perr, output par_flip_i,
`endif
    output wr_en, wr_ctx, wr_idx, wr_data, clr_en, clr_ctx, rd_en, rd_ctx, rd_idx,
    input  rd_valid, rd_err, rd_data, ctx_ready
  );
  modport slave (
`ifdef KEY_RAM_PARITY_EN
    output perr, input par_flip_i,
`endif
    input  wr_en, wr_ctx, wr_idx, wr_data, clr_en, clr_ctx, rd_en, rd_ctx, rd_idx,
    output rd_valid, rd_err, rd_data, ctx_ready
  );
endinterface

// File: rtl/key_ram_mc.sv
// key_ram_mc: NCTX sets of NKEYS round keys, 2-cycle read of UNROLL wrapped lanes.
// Optional per-word even parity with perr output under KEY_RAM_PARITY_EN.
module key_ram_mc #(
  parameter int UNROLL = 1,
  parameter int NKEYS  = 10,
  parameter int NCTX   = 2,
  parameter int DW     = 128
) (
  input logic    clk,
  input logic    rst_n,
  key_ram_if.slave bus
);
  localparam int IW = $clog2(NKEYS);
  localparam int CW = NCTX > 1 ? $clog2(NCTX) : 1;
  localparam logic [IW:0] NK = (IW+1)'(NKEYS);
  localparam logic [CW:0] NC = (CW+1)'(NCTX);

  logic [DW-1:0]        mem [NCTX][NKEYS];
  logic [NKEYS-1:0]     mask [NCTX];
  logic [NKEYS-1:0]     mask_nxt [NCTX];
  logic                 wr_ok, rd_bad, s1_v, s1_err;
  logic [CW-1:0]        s1_ctx;
  logic [IW-1:0]        s1_idx;
  logic [DW*UNROLL-1:0] lanes;
`ifdef KEY_RAM_PARITY_EN
  logic                 par [NCTX][NKEYS];
  logic [UNROLL-1:0]    pmis;
`endif

  function automatic logic [IW-1:0] wrap(input logic [IW:0] s);
    return s >= NK ? IW'(s - NK) : IW'(s);
  endfunction

  assign wr_ok  = bus.wr_en && {1'b0, bus.wr_idx} < NK && {1'b0, bus.wr_ctx} < NC;
  assign rd_bad = {1'b0, bus.rd_idx} >= NK || {1'b0, bus.rd_ctx} >= NC || !(&mask[bus.rd_ctx]);

  // clear takes effect before a same-cycle write to the same context
  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      mask_nxt[c] = (bus.clr_en && bus.clr_ctx == CW'(c)) ? '0 : mask[c];
      if (wr_ok && bus.wr_ctx == CW'(c)) mask_nxt[c][bus.wr_idx] = 1'b1;
    end
  end

  always_comb begin
    lanes = '0;
`ifdef KEY_RAM_PARITY_EN
    pmis = '0;
`endif
    for (int i = 0; i < UNROLL; i++) begin
      lanes[i*DW +: DW] = mem[s1_ctx][wrap({1'b0, s1_idx} + (IW+1)'(i))];
`ifdef KEY_RAM_PARITY_EN
      pmis[i] = ^mem[s1_ctx][wrap({1'b0, s1_idx} + (IW+1)'(i))] ^ par[s1_ctx][wrap({1'b0, s1_idx} + (IW+1)'(i))];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.wr_ctx][bus.wr_idx] <= bus.wr_data;
`ifdef KEY_RAM_PARITY_EN
      par[bus.wr_ctx][bus.wr_idx] <= ^bus.wr_data ^ bus.par_flip_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCTX; c++) mask[c] <= '0;
      bus.ctx_ready <= '0;
      s1_v          <= 1'b0;
      s1_err        <= 1'b0;
      s1_ctx        <= '0;
      s1_idx        <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.rd_data   <= '0;
`ifdef KEY_RAM_PARITY_EN
      bus.perr      <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < NCTX; c++) begin
        mask[c]          <= mask_nxt[c];
        bus.ctx_ready[c] <= &mask_nxt[c];
      end
      s1_v         <= bus.rd_en;
      s1_err       <= rd_bad;
      s1_ctx       <= bus.rd_ctx;
      s1_idx       <= bus.rd_idx;
      bus.rd_valid <= s1_v;
      bus.rd_err   <= s1_v && s1_err;
      bus.rd_data  <= s1_v ? (s1_err ? '0 : lanes) : bus.rd_data;
`ifdef KEY_RAM_PARITY_EN
      bus.perr     <= s1_v && !s1_err && |pmis;
`endif
    end
  end
endmodule

// File: tb/tb_key_ram_mc.sv
// tb_key_ram_mc: scoreboard bench for key_ram_mc (UNROLL=3, NKEYS=10, NCTX=2).
// Expected reads are modelled when issued and checked when rd_valid appears.
module tb_key_ram_mc;
  localparam int U = 3, NK = 10, NC = 2, DW = 128;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  key_ram_if #(.UNROLL(U), .NKEYS(NK), .NCTX(NC), .DW(DW)) bus ();
  key_ram_mc #(.UNROLL(U), .NKEYS(NK), .NCTX(NC), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {logic err; logic perr; logic [U*DW-1:0] data; int cyc;} exp_t;
  exp_t sb[$];
  exp_t got;
  logic [DW-1:0]   km [NC][NK];
  logic [NK-1:0]   mm [NC];
  logic            pf [NC][NK];
  logic [U*DW-1:0] last_data;
  int vectors = 0, miscompares = 0, cyc = 0, nvalid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) last_data = '0;
    else if (bus.rd_valid) begin
      nvalid++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: rd_valid=1 at cycle %0d, no read pending", cyc);
      end else begin
        got = sb.pop_front();
        if (bus.rd_err !== got.err || bus.rd_data !== got.data || cyc != got.cyc
`ifdef KEY_RAM_PARITY_EN
            || bus.perr !== got.perr
`endif
           ) begin
          miscompares++;
          $display("FAIL read_result: got err=%b data=%h cyc=%0d, expected err=%b data=%h cyc=%0d",
                   bus.rd_err, bus.rd_data, cyc, got.err, got.data, got.cyc);
        end
      end
      last_data = bus.rd_data;
    end else if (bus.rd_err !== 1'b0 || bus.rd_data !== last_data) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_outputs: got err=%b data=%h, expected err=0 data=%h", bus.rd_err, bus.rd_data, last_data);
    end
  end

  task automatic clear_inputs();
    bus.wr_en = 0; bus.wr_ctx = 0; bus.wr_idx = 0; bus.wr_data = 0;
    bus.clr_en = 0; bus.clr_ctx = 0;
    bus.rd_en = 0; bus.rd_ctx = 0; bus.rd_idx = 0;
`ifdef KEY_RAM_PARITY_EN
    bus.par_flip_i = 0;
`endif
  endtask

  // one clock: model the read's error from pre-edge state, its data after this cycle's writes
  task automatic step();
    exp_t e;
    int j;
    logic err;
    err = 1'b1;
    if (bus.rd_en && int'(bus.rd_idx) < NK && int'(bus.rd_ctx) < NC) err = (mm[bus.rd_ctx] != '1);
    if (bus.clr_en && int'(bus.clr_ctx) < NC) mm[bus.clr_ctx] = '0;
    if (bus.wr_en && int'(bus.wr_idx) < NK && int'(bus.wr_ctx) < NC) begin
      km[bus.wr_ctx][bus.wr_idx] = bus.wr_data;
      mm[bus.wr_ctx][bus.wr_idx] = 1'b1;
`ifdef KEY_RAM_PARITY_EN
      pf[bus.wr_ctx][bus.wr_idx] = bus.par_flip_i;
`else
      pf[bus.wr_ctx][bus.wr_idx] = 1'b0;
`endif
    end
    if (bus.rd_en) begin
      e.err = err; e.perr = 1'b0; e.data = '0; e.cyc = cyc + 2;
      if (!err)
        for (int i = 0; i < U; i++) begin
          j = (int'(bus.rd_idx) + i) % NK;
          e.data[i*DW +: DW] = km[bus.rd_ctx][j];
          e.perr |= pf[bus.rd_ctx][j];
        end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d reads got no rd_valid, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic write(input int c, input int i, input logic [DW-1:0] d);
    bus.wr_en = 1; bus.wr_ctx = c[0]; bus.wr_idx = i[3:0]; bus.wr_data = d;
  endtask

  task automatic read(input int c, input int i);
    bus.rd_en = 1; bus.rd_ctx = c[0]; bus.rd_idx = i[3:0];
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    sb.delete();
    for (int c = 0; c < NC; c++) mm[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.rd_valid !== 0 || bus.rd_err !== 0 || bus.rd_data !== '0 || bus.ctx_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b err=%b ready=%b data=%h, expected all 0",
               bus.rd_valid, bus.rd_err, bus.ctx_ready, bus.rd_data);
    end
    rst_n = 1;
    #2;
    read(0, 0); step();
    drain("reset_read");
  endtask

  task automatic test_load();
    for (int i = 0; i < NK; i++) begin
      write(0, i, 128'h1000 + i); step();
      vectors++;
      if (bus.ctx_ready[0] !== (i == NK - 1)) begin
        miscompares++;
        $display("FAIL load_ready: after write %0d got ctx_ready[0]=%b, expected %b", i, bus.ctx_ready[0], i == NK - 1);
      end
    end
    read(0, 9); step();
    read(0, 0); step();
    read(0, 8); step();
    drain("load_read");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NK; i++) begin write(1, i, 128'h2000 + i); step(); end
    vectors++;
    if (bus.ctx_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL b2b_ready: got ctx_ready=%b, expected 11", bus.ctx_ready);
    end
    for (int k = 0; k < 4; k++) begin read(k % 2, 2); step(); end
    drain("b2b");
  endtask

  task automatic test_ordering();
    read(0, 4); step();
    write(0, 4, 128'hBEEF); step();
    drain("order_late_write");
    read(0, 4); write(0, 4, 128'hCAFE); step();
    drain("order_same_write");
  endtask

  task automatic test_clear();
    bus.clr_en = 1; bus.clr_ctx = 0; write(0, 3, 128'h1003); step();
    vectors++;
    if (bus.ctx_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL clear_ready: got ctx_ready=%b, expected 10", bus.ctx_ready);
    end
    read(0, 0); step();
    read(1, 12); step();
    write(1, 12, 128'hDEAD); step();
    drain("clear_err");
    for (int i = 0; i < NK; i++) begin
      if (i == 3) continue;
      write(0, i, 128'h3000 + i); step();
      vectors++;
      if (bus.ctx_ready[0] !== (i == NK - 1)) begin
        miscompares++;
        $display("FAIL reload_ready: after idx %0d got ctx_ready[0]=%b, expected %b", i, bus.ctx_ready[0], i == NK - 1);
      end
    end
    read(0, 2); step();
    read(0, 1); step();
    bus.clr_en = 1; bus.clr_ctx = 0; step();
    vectors++;
    if (bus.ctx_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL inflight_clear: got ctx_ready=%b, expected 10", bus.ctx_ready);
    end
    drain("clear_inflight");
  endtask

`ifdef KEY_RAM_PARITY_EN
  task automatic test_parity();
    write(1, 5, 128'h2005); bus.par_flip_i = 1; step();
    read(1, 5); step();
    read(1, 3); step();
    read(1, 6); step();
    drain("parity_bad");
    write(1, 5, 128'h2005); step();
    read(1, 5); step();
    drain("parity_good");
  endtask
`endif

  task automatic test_async_reset();
    int seen;
    read(1, 0); step();
    seen = nvalid;
    #2;
    rst_n = 0;
    sb.delete();
    for (int c = 0; c < NC; c++) mm[c] = '0;
    #1;
    vectors++;
    if (bus.rd_valid !== 0 || bus.ctx_ready !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b ready=%b, expected 0 and 00", bus.rd_valid, bus.ctx_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (nvalid != seen) begin
      miscompares++;
      $display("FAIL async_drop: got %0d rd_valid pulses after reset, expected 0", nvalid - seen);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_ordering();
    test_clear();
`ifdef KEY_RAM_PARITY_EN
    test_parity();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
